// File: rtl/serial_mode_sequencer.sv
// ---------------------------------------------------------------------------
// serial_mode_sequencer
//
// Control and writeback stage wrapped around the serial-mode datapath
// (Serial_Data_loader + PE). For each output index the block enables the
// datapath with the current feature base address. It waits for the datapath
// done flag, captures the 8-bit PE result and writes it into result memory.
// The feature base address then advances by FEAT_STRIDE for the next index.
// A single done pulse is raised once NUM_OUT results have been written.
//
// Parameters:
//   NUM_OUT       number of serial-mode operations per run (1..64)
//   FEAT_STRIDE   increment applied to the feature base between operations
//   RES_BASEADDR  first result-memory word address (6-bit, wraps mod 64)
//   TIMEOUT_CYC   watchdog limit in RUN cycles (only with SEQ_TIMEOUT_EN)
//
// Optional feature (macro SEQ_TIMEOUT_EN):
//   When defined, a 9-bit watchdog counts RUN cycles. If the datapath never
//   signals done, 8'hFF is written for that index, the sticky err_o is set,
//   and the run continues with the next index. When undefined, RUN waits
//   indefinitely and err_o is tied low.
//
// Ports:
//   clk                  system clock
//   rst                  synchronous active-high reset
//   start                one-cycle start request, honoured only in IDLE
//   feat_base_start      feature base address of operation 0
//   sm_is_done           done flag from the serial-mode datapath
//   sm_out               PE serial-mode result
//   sm_en                enable to the serial-mode datapath
//   sm_feature_baseaddr  feature base address of the current operation
//   wr_addr              result-memory write address
//   wr_data              result-memory write data
//   wr_we                result-memory write enable (also claims the memory mux)
//   busy                 high from accepted start until the run completes
//   done_o               one-cycle pulse when the run completes
//   err_o                sticky watchdog timeout flag
// ---------------------------------------------------------------------------
module serial_mode_sequencer #(
    parameter int unsigned NUM_OUT      = 4,
    parameter int unsigned FEAT_STRIDE  = 8,
    parameter int unsigned RES_BASEADDR = 48,
    parameter int unsigned TIMEOUT_CYC  = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] feat_base_start,
    input  logic       sm_is_done,
    input  logic [7:0] sm_out,
    output logic       sm_en,
    output logic [7:0] sm_feature_baseaddr,
    output logic [5:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       wr_we,
    output logic       busy,
    output logic       done_o,
    output logic       err_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_WRITE,
        S_GAP,
        S_FIN
    } state_t;

    localparam logic [5:0] LAST_IDX    = 6'(NUM_OUT - 1);
    localparam logic [5:0] RES_BASE    = 6'(RES_BASEADDR);
    localparam logic [7:0] FEAT_STEP   = 8'(FEAT_STRIDE);

    // Out-of-range parameters cannot be represented by the 6-bit index or
    // the 9-bit watchdog, so they are rejected at elaboration.
    generate
        if (NUM_OUT < 1 || NUM_OUT > 64 || TIMEOUT_CYC < 1 || TIMEOUT_CYC > 511) begin : g_param_check
            $error("serial_mode_sequencer: illegal NUM_OUT or TIMEOUT_CYC");
        end
    endgenerate

    state_t     state_q, state_d;
    logic [5:0] idx_q, idx_d;
    logic [7:0] base_q, base_d;
    logic       first_q, first_d;
    logic       sm_en_q, sm_en_d;
    logic       wr_we_q, wr_we_d;
    logic [5:0] wr_addr_q, wr_addr_d;
    logic [7:0] wr_data_q, wr_data_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       err_q, err_d;

`ifdef SEQ_TIMEOUT_EN
    localparam logic [8:0] WD_LIMIT = 9'(TIMEOUT_CYC);
    logic [8:0] wd_q, wd_d;
`endif

    // Next-state and next-output computation. first_q marks the first cycle of
    // every RUN visit. A done flag seen in that cycle may be left over from
    // the previous operation, so it is not trusted.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        base_d    = base_q;
        first_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        err_d     = err_q;
`ifdef SEQ_TIMEOUT_EN
        wd_d      = wd_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    base_d  = feat_base_start;
                    idx_d   = 6'd0;
                    first_d = 1'b1;
                    state_d = S_RUN;
`ifdef SEQ_TIMEOUT_EN
                    wd_d    = 9'd0;
`endif
                end
            end

            S_RUN: begin
`ifdef SEQ_TIMEOUT_EN
                wd_d = wd_q + 9'd1;
`endif
                if (!first_q && sm_is_done) begin
                    wr_data_d = sm_out;
                    wr_addr_d = RES_BASE + idx_q;
                    state_d   = S_WRITE;
                end
`ifdef SEQ_TIMEOUT_EN
                else if (wd_q + 9'd1 >= WD_LIMIT) begin
                    // Datapath never answered: write a marker value and move on.
                    wr_data_d = 8'hFF;
                    wr_addr_d = RES_BASE + idx_q;
                    err_d     = 1'b1;
                    state_d   = S_WRITE;
                end
`endif
            end

            S_WRITE: begin
                if (idx_q == LAST_IDX) begin
                    state_d = S_FIN;
                end else begin
                    idx_d   = idx_q + 6'd1;
                    base_d  = base_q + FEAT_STEP;
                    state_d = S_GAP;
                end
            end

            // One idle cycle with sm_en low so the loader sees a fresh rising edge.
            S_GAP: begin
                first_d = 1'b1;
                state_d = S_RUN;
`ifdef SEQ_TIMEOUT_EN
                wd_d    = 9'd0;
`endif
            end

            S_FIN: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Outputs are decoded from the next state so they are registered
        // alongside the state and line up with it cycle for cycle.
        sm_en_d = (state_d == S_RUN);
        wr_we_d = (state_d == S_WRITE);
        busy_d  = (state_d == S_RUN) || (state_d == S_WRITE) || (state_d == S_GAP);
        done_d  = (state_d == S_FIN);
    end

    // State and registered outputs with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            idx_q     <= 6'd0;
            base_q    <= 8'd0;
            first_q   <= 1'b0;
            sm_en_q   <= 1'b0;
            wr_we_q   <= 1'b0;
            wr_addr_q <= 6'd0;
            wr_data_q <= 8'd0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
`ifdef SEQ_TIMEOUT_EN
            wd_q      <= 9'd0;
`endif
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            base_q    <= base_d;
            first_q   <= first_d;
            sm_en_q   <= sm_en_d;
            wr_we_q   <= wr_we_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
`ifdef SEQ_TIMEOUT_EN
            wd_q      <= wd_d;
`endif
        end
    end

    assign sm_en               = sm_en_q;
    assign sm_feature_baseaddr = base_q;
    assign wr_addr             = wr_addr_q;
    assign wr_data             = wr_data_q;
    // A reset arriving during WRITE must suppress that write immediately,
    // before the synchronous reset has had a chance to clear the flop.
    assign wr_we               = wr_we_q && !rst;
    assign busy                = busy_q;
    assign done_o              = done_q;

`ifdef SEQ_TIMEOUT_EN
    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_serial_mode_sequencer.sv
// ---------------------------------------------------------------------------
// tb_serial_mode_sequencer
//
// Self-checking bench for serial_mode_sequencer. A small datapath model answers
// each sm_en rising edge with result (op index + 10) after LAT cycles. It can
// also hold done high permanently, or never answer operation 0. Expected
// writes and expected base addresses are queued when a run is started. They
// are popped as the DUT writes and raises sm_en.
// Covers: reset, basic run, address wrap, stale done, start while busy, reset
// mid-op, and the watchdog when SEQ_TIMEOUT_EN is defined.
// ---------------------------------------------------------------------------
module tb_serial_mode_sequencer;

    localparam int NUM_OUT = 4;
    localparam int STRIDE  = 8;
    localparam int RES     = 62;
    localparam int TMO     = 20;
    localparam int LAT     = 18;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] feat_base_start;
    logic       sm_is_done;
    logic [7:0] sm_out;
    logic       sm_en;
    logic [7:0] sm_feature_baseaddr;
    logic [5:0] wr_addr;
    logic [7:0] wr_data;
    logic       wr_we;
    logic       busy;
    logic       done_o;
    logic       err_o;

    int tests_run    = 0;
    int tests_failed = 0;
    int done_cnt     = 0;
    int mode         = 0;
    logic tb_prev_en = 1'b0;

    logic [5:0] exp_addr[$];
    logic [7:0] exp_data[$];
    logic [7:0] exp_base[$];

    serial_mode_sequencer #(
        .NUM_OUT     (NUM_OUT),
        .FEAT_STRIDE (STRIDE),
        .RES_BASEADDR(RES),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .start              (start),
        .feat_base_start    (feat_base_start),
        .sm_is_done         (sm_is_done),
        .sm_out             (sm_out),
        .sm_en              (sm_en),
        .sm_feature_baseaddr(sm_feature_baseaddr),
        .wr_addr            (wr_addr),
        .wr_data            (wr_data),
        .wr_we              (wr_we),
        .busy               (busy),
        .done_o             (done_o),
        .err_o              (err_o)
    );

    always #5 clk = ~clk;

    // Datapath model: mode 0 pulses done LAT cycles after sm_en rises,
    // mode 1 holds done high forever, mode 2 never answers operation 0.
    int   op_cnt = 0;
    int   cur_op = 0;
    int   cyc    = 0;
    logic model_prev_en   = 1'b0;
    logic model_prev_busy = 1'b0;

    initial begin
        sm_is_done = 1'b0;
        sm_out     = 8'd0;
    end

    always @(negedge clk) begin
        if (busy === 1'b1 && model_prev_busy !== 1'b1) op_cnt = 0;
        if (sm_en === 1'b1 && model_prev_en !== 1'b1) begin
            cur_op = op_cnt;
            op_cnt = op_cnt + 1;
            cyc    = 0;
            sm_out = 8'(cur_op + 10);
        end
        if (sm_en === 1'b1) cyc = cyc + 1;
        case (mode)
            1:       sm_is_done = 1'b1;
            2:       sm_is_done = (sm_en === 1'b1) && (cur_op != 0) && (cyc == LAT);
            default: sm_is_done = (sm_en === 1'b1) && (cyc == LAT);
        endcase
        model_prev_en   = sm_en;
        model_prev_busy = busy;
    end

    // Advance one cycle and run the scoreboard on the sampled outputs.
    task automatic tick();
        logic [5:0] a;
        logic [7:0] d;
        logic [7:0] b;
        @(negedge clk);
        tests_run++;
        if (sm_en === 1'b1 && wr_we === 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL en_we_exclusive: sm_en=%b wr_we=%b required not both 1", sm_en, wr_we);
        end
        if (wr_we === 1'b1) begin
            tests_run++;
            if (exp_addr.size() == 0) begin
                tests_failed++;
                $display("[TB] FAIL unexpected_write: addr=%0d data=%0h with no write pending", wr_addr, wr_data);
            end else begin
                a = exp_addr.pop_front();
                d = exp_data.pop_front();
                if (wr_addr !== a || wr_data !== d) begin
                    tests_failed++;
                    $display("[TB] FAIL write: got addr=%0d data=%0h required addr=%0d data=%0h", wr_addr, wr_data, a, d);
                end
            end
        end
        if (sm_en === 1'b1 && tb_prev_en !== 1'b1) begin
            tests_run++;
            if (exp_base.size() == 0) begin
                tests_failed++;
                $display("[TB] FAIL unexpected_op: sm_en rose with base=%0h, no op pending", sm_feature_baseaddr);
            end else begin
                b = exp_base.pop_front();
                if (sm_feature_baseaddr !== b) begin
                    tests_failed++;
                    $display("[TB] FAIL base_addr: got %0h required %0h", sm_feature_baseaddr, b);
                end
            end
        end
        tb_prev_en = sm_en;
        if (done_o === 1'b1) done_cnt++;
    endtask

    task automatic push_run(input logic [7:0] base, input bit tmo_first);
        for (int i = 0; i < NUM_OUT; i++) begin
            exp_base.push_back(8'(int'(base) + i * STRIDE));
            exp_addr.push_back(6'(RES + i));
            exp_data.push_back((tmo_first && i == 0) ? 8'hFF : 8'(10 + i));
        end
    endtask

    task automatic start_run(input logic [7:0] base, input string name);
        done_cnt        = 0;
        feat_base_start = base;
        start           = 1'b1;
        tick();
        start           = 1'b0;
        tests_run++;
        if (busy !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL %s_busy_after_start: got %b required 1", name, busy);
        end
    endtask

    task automatic wait_done(input string name, input int budget);
        int n = 0;
        while (done_cnt == 0 && n < budget) begin
            tick();
            n++;
        end
        if (done_cnt == 0) begin
            tests_run++;
            tests_failed++;
            $display("[TB] FAIL %s_done_wait: no done_o after %0d cycles", name, budget);
        end
    endtask

    task automatic finish_check(input string name);
        repeat (3) tick();
        tests_run++;
        if (exp_addr.size() != 0) begin
            tests_failed++;
            $display("[TB] FAIL %s_writes_left: got %0d pending required 0", name, exp_addr.size());
        end
        tests_run++;
        if (exp_base.size() != 0) begin
            tests_failed++;
            $display("[TB] FAIL %s_ops_left: got %0d pending required 0", name, exp_base.size());
        end
        tests_run++;
        if (done_cnt != 1) begin
            tests_failed++;
            $display("[TB] FAIL %s_done_pulses: got %0d required 1", name, done_cnt);
        end
        tests_run++;
        if (busy !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL %s_busy_end: got %b required 0", name, busy);
        end
    endtask

    task automatic check_all_zero(input string name);
        tests_run++;
        if ({sm_en, wr_we, busy, done_o, err_o} !== 5'b0) begin
            tests_failed++;
            $display("[TB] FAIL %s_ctrl: got en=%b we=%b busy=%b done=%b err=%b required all 0",
                     name, sm_en, wr_we, busy, done_o, err_o);
        end
        tests_run++;
        if ({sm_feature_baseaddr, wr_addr, wr_data} !== 22'd0) begin
            tests_failed++;
            $display("[TB] FAIL %s_data: got base=%0h addr=%0d data=%0h required 0",
                     name, sm_feature_baseaddr, wr_addr, wr_data);
        end
    endtask

    task automatic clear_queues();
        exp_addr.delete();
        exp_data.delete();
        exp_base.delete();
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        start = 1'b0;
        feat_base_start = 8'd0;
        repeat (3) tick();
        check_all_zero("reset");
        rst = 1'b0;
        repeat (2) tick();
        check_all_zero("reset_idle");
    endtask

    task automatic test_basic();
        mode = 0;
        push_run(8'h00, 1'b0);
        start_run(8'h00, "basic");
        wait_done("basic", 1000);
        finish_check("basic");
        tests_run++;
        if (err_o !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL basic_err: got %b required 0", err_o);
        end
    endtask

    task automatic test_wrap();
        mode = 0;
        push_run(8'hF8, 1'b0);
        start_run(8'hF8, "wrap");
        wait_done("wrap", 1000);
        finish_check("wrap");
    endtask

    task automatic test_stale_done();
        mode = 1;
        push_run(8'h10, 1'b0);
        start_run(8'h10, "stale");
        wait_done("stale", 1000);
        finish_check("stale");
        mode = 0;
        repeat (2) tick();
    endtask

    task automatic test_start_while_busy();
        int n = 0;
        mode = 0;
        push_run(8'h30, 1'b0);
        start_run(8'h30, "busy_start");
        while (exp_base.size() > 1 && n < 500) begin
            tick();
            n++;
        end
        repeat (5) tick();
        feat_base_start = 8'h55;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done("busy_start", 1000);
        finish_check("busy_start");
    endtask

    task automatic test_reset_mid_op();
        int n = 0;
        mode = 0;
        push_run(8'h40, 1'b0);
        start_run(8'h40, "rst_mid");
        while (exp_base.size() > 2 && n < 500) begin
            tick();
            n++;
        end
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_all_zero("rst_mid");
        clear_queues();
        repeat (3) tick();
        tests_run++;
        if (busy !== 1'b0 || sm_en !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL rst_mid_idle: got busy=%b en=%b required 0 0", busy, sm_en);
        end
        push_run(8'h20, 1'b0);
        start_run(8'h20, "rst_restart");
        wait_done("rst_restart", 1000);
        finish_check("rst_restart");
    endtask

`ifdef SEQ_TIMEOUT_EN
    task automatic test_timeout();
        mode = 2;
        push_run(8'h00, 1'b1);
        start_run(8'h00, "timeout");
        wait_done("timeout", 1500);
        finish_check("timeout");
        tests_run++;
        if (err_o !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL timeout_err: got %b required 1", err_o);
        end
        mode = 0;
    endtask
`endif

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        feat_base_start = 8'd0;
        test_reset();
        test_basic();
        test_wrap();
        test_stale_done();
        test_start_while_busy();
        test_reset_mid_op();
`ifdef SEQ_TIMEOUT_EN
        test_timeout();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/serial_mode_sequencer.md
Name: serial_mode_sequencer

Overview:
- Control and writeback stage that wraps around the serial-mode datapath (Serial_Data_loader + PE).
- Issues one serial-mode dot-product per output index, advancing the feature base address each time.
- Waits for the datapath done flag, captures the 8-bit PE result and writes it into result memory.
- Raises a single done pulse after NUM_OUT results have been written.

Parameters:
- NUM_OUT, 4: number of serial-mode operations per run (1..64).
- FEAT_STRIDE, 8: increment added to the feature base address between operations.
- RES_BASEADDR, 48: first result-memory word address (6-bit).
- TIMEOUT_CYC, 255: watchdog limit in RUN cycles; used only with SEQ_TIMEOUT_EN.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- start  in  1  one-cycle start request; sampled in IDLE only
- feat_base_start  in  8  feature base address for operation 0; latched on accepted start
- sm_is_done  in  1  done flag from the serial-mode datapath
- sm_out  in  8  PE serial-mode result
- sm_en  out  1  enable to the serial-mode datapath
- sm_feature_baseaddr  out  8  feature base address for the current operation
- wr_addr  out  6  result-memory write address
- wr_data  out  8  result-memory write data
- wr_we  out  1  result-memory write enable; the external mux gives memory to this block when wr_we=1
- busy  out  1  high from accepted start until done_o
- done_o  out  1  one-cycle pulse when the run completes
- err_o  out  1  sticky timeout flag (tied 0 without SEQ_TIMEOUT_EN)

Behaviour:
- Reset (sync, active-high, any state): state=IDLE, idx=0. All outputs 0, including sm_feature_baseaddr, wr_addr and wr_data.
- States and transitions:
  - IDLE: busy=0. On start=1: latch feat_base_start into base_r, idx<=0, go to RUN.
  - RUN: sm_en=1, sm_feature_baseaddr=base_r, busy=1.
    - sm_is_done is ignored in the first RUN cycle, which masks a stale done from the previous op.
    - From the second cycle on, sm_is_done=1 registers sm_out into wr_data and goes to WRITE.
  - WRITE: sm_en=0, wr_we=1 for exactly one cycle, wr_addr=(RES_BASEADDR+idx) mod 64.
    - If idx==NUM_OUT-1, go to FIN.
    - Otherwise idx<=idx+1, base_r<=(base_r+FEAT_STRIDE) mod 256, go to GAP.
  - GAP: sm_en=0 for one cycle so the loader re-arms on the following rising edge of en. Then go to RUN.
  - FIN: done_o=1 for one cycle, busy=0, go to IDLE.
- Latency: each op costs (datapath cycles to done) + 1 RUN mask cycle + WRITE + GAP. The final op has FIN instead of GAP.
- wr_we and sm_en are never high in the same cycle.
- start while busy is ignored; start in the FIN cycle is ignored.
- wr_data and wr_addr hold their last values outside WRITE. wr_we=0 outside WRITE.
- Address arithmetic:
  - Feature address wraps modulo 256.
  - Result address wraps modulo 64; NUM_OUT>64 is illegal.
- NUM_OUT=1: a single RUN→WRITE→FIN with no GAP.
- sm_is_done held high for several cycles: only the first qualifying cycle is consumed. GAP plus the RUN mask cover the rest.
- Reset mid-RUN or mid-WRITE aborts immediately. No write occurs in the reset cycle; the next cycle is IDLE.

Optional Feature:
- Macro SEQ_TIMEOUT_EN.
- Defined:
  - A 9-bit watchdog counts RUN cycles and clears on entering RUN.
  - When the count reaches TIMEOUT_CYC without done, the block sets err_o (sticky until rst), drops sm_en, and writes 8'hFF at the current wr_addr via WRITE.
  - It then continues with the next index.
- Not defined: no counter, err_o tied 0, RUN waits indefinitely.

Test Plan:
- Basic run: rst; NUM_OUT=4, feat_base_start=8'h00, done model returns out=idx+10 after 18 cycles → writes 10,11,12,13 to addrs 48..51; baseaddr sequence 0,8,16,24; one done_o pulse; busy low after.
- Wrap: feat_base_start=8'hF8, FEAT_STRIDE=8 → second op baseaddr=8'h00. With RES_BASEADDR=62, writes land at 62,63,0,1.
- Stale done: hold sm_is_done=1 continuously from the model → exactly one write per op, each preceded by a sm_en low cycle (GAP), 4 writes total.
- Start while busy: pulse start mid-op 2 → no restart, base/idx unaffected, still exactly 4 writes.
- Reset mid-op: assert rst during RUN of op 1 → next cycle all outputs 0, no write. A new start restarts from idx 0.
- Timeout (SEQ_TIMEOUT_EN, TIMEOUT_CYC=20): model never asserts done for op 0 → after 20 RUN cycles, 8'hFF written to addr 48, err_o=1, ops 1..3 complete normally.
